// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge
//  Turns the core's data-side sram-like handshake (req/addr_ok/data_ok) into
//  single-beat AXI master transactions. Only one transaction is in flight.
//  Optional build macro: BRIDGE_FAST_RESP_EN. When it is defined, the DONE
//  state is dropped and data_ok/rdata come straight from rvalid/bvalid and
//  axi_rdata in the response cycle.
module data_sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // core side
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  // AXI read address / data
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address / data / response
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

`ifdef BRIDGE_FAST_RESP_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WR_REQ, ST_WR_RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WR_REQ, ST_WR_RESP, ST_DONE
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            size_q;
  logic [2:0]            size_d;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  accept;

  // AXI size encoding: size 3 is not a legal core size and is treated as a word.
  always_comb begin
    size_d = (size == 2'b11) ? 3'b010 : {1'b0, size};
  end

  // State, handshake flags and read-data holding register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request capture: address/control/data are frozen for the whole transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      size_q  <= 3'b000;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      size_q  <= size_d;
      wstrb_q <= wstrb;
      wdata_q <= wdata;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    accept    = 1'b0;
    addr_ok   = (state_q == ST_IDLE);
    arvalid   = (state_q == ST_RD_ADDR);
    rready    = (state_q == ST_RD_DATA);
    bready    = (state_q == ST_WR_RESP);
    awvalid   = (state_q == ST_WR_REQ) && !aw_done_q;
    wvalid    = (state_q == ST_WR_REQ) && !w_done_q;
    data_ok   = 1'b0;
    rdata     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          rdata_d = axi_rdata;
`ifdef BRIDGE_FAST_RESP_EN
          data_ok = 1'b1;
          rdata   = axi_rdata;
          state_d = ST_IDLE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_WR_REQ: begin
        // Flags are registered, so the move to WR_RESP happens the cycle
        // after the later of the two handshakes.
        if (aw_done_q && w_done_q) begin
          state_d = ST_WR_RESP;
        end else begin
          if (awvalid && awready) aw_done_d = 1'b1;
          if (wvalid && wready)   w_done_d  = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
`ifdef BRIDGE_FAST_RESP_EN
          data_ok = 1'b1;
          state_d = ST_IDLE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifndef BRIDGE_FAST_RESP_EN
      ST_DONE: begin
        data_ok = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Both channels share the captured request; address passes through unaligned.
  assign araddr    = addr_q;
  assign arsize    = size_q;
  assign awaddr    = addr_q;
  assign awsize    = size_q;
  assign axi_wdata = wdata_q;
  assign axi_wstrb = wstrb_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Testbench for data_sram_axi_bridge: the bench plays core and AXI slave,
// randomises wait states, and predicts every output per cycle from the
// transaction timing rules (phase windows computed from wait counts).
module tb_data_sram_axi_bridge;

`ifdef BRIDGE_FAST_RESP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, resetn, req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata, araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] axi_rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'h0;

  data_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0;
    wdata = 32'h0; arready = 1'b0; axi_rdata = 32'h0; rvalid = 1'b0; awready = 1'b0;
    wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", bready); end
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    resetn = 1'b1;
    tick();
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL post_reset_addr_ok: got %b want 1", addr_ok); end
    checks++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || data_ok !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got ar=%b aw=%b w=%b dok=%b want 0000", arvalid, awvalid, wvalid, data_ok);
    end
    $display("reset: released, bridge idle");
  endtask

  // Stray responses while idle must be ignored.
  task automatic test_stray_idle(input int n);
    for (int c = 0; c < n; c++) begin
      req = 1'b0; rvalid = 1'($urandom_range(0, 1)); bvalid = 1'($urandom_range(0, 1));
      axi_rdata = $urandom; arready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL stray_idle_data_ok: got %b want 0", data_ok); end
      checks++; if (rdata !== last_rdata) begin errors++; $display("FAIL stray_idle_rdata: got %h want %h", rdata, last_rdata); end
      checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL stray_idle_addr_ok: got %b want 1", addr_ok); end
      tick();
    end
    $display("stray_idle: %0d cycles of stray responses", n);
  endtask

  task automatic test_read(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      logic [2:0]  exp_sz;
      int arw, rw, done_c, lat;
      lat = 0;
      if (t == 0 && n > 4) begin
        a = 32'h1c00_0010; sz = 2'd2; d = 32'hDEADBEEF; arw = 0; rw = 0;
      end else if (t == 1) begin
        a = $urandom; sz = 2'($urandom_range(0, 3)); d = $urandom; arw = 5; rw = 0;
      end else begin
        a = $urandom; sz = 2'($urandom_range(0, 3)); d = $urandom;
        arw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      end
      exp_sz = (sz == 2'd3) ? 3'b010 : {1'b0, sz};
      done_c = FAST ? (2 + arw + rw) : (3 + arw + rw);
      // cycle 0: request presented while idle
      req = 1'b1; wr = 1'b0; addr = a; size = sz; wstrb = 4'($urandom); wdata = $urandom;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      #1;
      checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL rd_addr_ok_idle: got %b want 1", addr_ok); end
      for (int c = 1; c <= done_c; c++) begin
        tick();
        req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); addr = $urandom;
        size = 2'($urandom_range(0, 3));
        arready = (c == 1 + arw);
        rvalid  = (c == 2 + arw + rw);
        axi_rdata = rvalid ? d : $urandom;
        awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
        bvalid = 1'($urandom_range(0, 1));
        #1;
        checks++; if (arvalid !== (c <= 1 + arw)) begin errors++; $display("FAIL rd_arvalid c%0d: got %b want %b", c, arvalid, (c <= 1 + arw)); end
        checks++; if (rready !== (c >= 2 + arw && c <= 2 + arw + rw)) begin errors++; $display("FAIL rd_rready c%0d: got %b", c, rready); end
        checks++; if (data_ok !== (c == done_c)) begin errors++; $display("FAIL rd_data_ok c%0d: got %b want %b", c, data_ok, (c == done_c)); end
        checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL rd_addr_ok_busy c%0d: got %b want 0", c, addr_ok); end
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL rd_write_chan c%0d: got aw=%b w=%b b=%b want 000", c, awvalid, wvalid, bready); end
        if (c <= 1 + arw) begin
          checks++; if (araddr !== a || arsize !== exp_sz) begin errors++; $display("FAIL rd_ar_payload c%0d: got %h/%b want %h/%b", c, araddr, arsize, a, exp_sz); end
        end
        checks++; if (rdata !== ((c == done_c) ? d : last_rdata)) begin errors++; $display("FAIL rd_rdata c%0d: got %h want %h", c, rdata, (c == done_c) ? d : last_rdata); end
        if (data_ok === 1'b1 && lat == 0) lat = c;
      end
      last_rdata = d;
      // back in idle: stray rvalid must not disturb anything
      tick();
      req = 1'b0; rvalid = 1'b1; axi_rdata = $urandom; arready = 1'b0; bvalid = 1'b0;
      #1;
      checks++; if (addr_ok !== 1'b1 || data_ok !== 1'b0) begin errors++; $display("FAIL rd_return_idle: got addr_ok=%b data_ok=%b want 1/0", addr_ok, data_ok); end
      checks++; if (rdata !== d) begin errors++; $display("FAIL rd_rdata_hold: got %h want %h", rdata, d); end
      $display("read  addr=%h size=%0d arwait=%0d rwait=%0d data=%h latency=%0d", a, sz, arw, rw, d, lat);
    end
  endtask

  task automatic test_write(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a, d;
      logic [3:0]  st;
      logic [1:0]  sz;
      logic [2:0]  exp_sz;
      int aww, ww, bw, h, bstart, bcyc, done_c;
      if (t == 0) begin
        a = 32'h1c00_0020; d = 32'h1234_5678; st = 4'b0011; sz = 2'd2; aww = 3; ww = 0; bw = 0;
      end else if (t == 1) begin
        a = $urandom; d = $urandom; st = 4'b0000; sz = 2'd3; aww = 0; ww = 2; bw = 1;
      end else begin
        a = $urandom; d = $urandom; st = 4'($urandom); sz = 2'($urandom_range(0, 3));
        aww = $urandom_range(0, 3); ww = $urandom_range(0, 3); bw = $urandom_range(0, 3);
      end
      exp_sz = (sz == 2'd3) ? 3'b010 : {1'b0, sz};
      h = 1 + ((aww > ww) ? aww : ww);
      bstart = h + 2;
      bcyc = bstart + bw;
      done_c = FAST ? bcyc : bcyc + 1;
      req = 1'b1; wr = 1'b1; addr = a; size = sz; wstrb = st; wdata = d;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      #1;
      checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL wr_addr_ok_idle: got %b want 1", addr_ok); end
      for (int c = 1; c <= done_c; c++) begin
        tick();
        req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); addr = $urandom;
        wdata = $urandom; wstrb = 4'($urandom); size = 2'($urandom_range(0, 3));
        awready = (c == 1 + aww);
        wready  = (c == 1 + ww);
        bvalid  = (c == bcyc) || (c < bstart && $urandom_range(0, 1) == 1);
        rvalid  = 1'($urandom_range(0, 1)); axi_rdata = $urandom;
        arready = 1'($urandom_range(0, 1));
        #1;
        checks++; if (awvalid !== (c <= 1 + aww)) begin errors++; $display("FAIL wr_awvalid c%0d: got %b want %b", c, awvalid, (c <= 1 + aww)); end
        checks++; if (wvalid !== (c <= 1 + ww)) begin errors++; $display("FAIL wr_wvalid c%0d: got %b want %b", c, wvalid, (c <= 1 + ww)); end
        checks++; if (bready !== (c >= bstart && c <= bcyc)) begin errors++; $display("FAIL wr_bready c%0d: got %b", c, bready); end
        checks++; if (data_ok !== (c == done_c)) begin errors++; $display("FAIL wr_data_ok c%0d: got %b want %b", c, data_ok, (c == done_c)); end
        checks++; if (addr_ok !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL wr_idle_outs c%0d: got aok=%b ar=%b r=%b want 000", c, addr_ok, arvalid, rready); end
        checks++; if (rdata !== last_rdata) begin errors++; $display("FAIL wr_rdata_hold c%0d: got %h want %h", c, rdata, last_rdata); end
        if (c <= 1 + aww) begin
          checks++; if (awaddr !== a || awsize !== exp_sz) begin errors++; $display("FAIL wr_aw_payload c%0d: got %h/%b want %h/%b", c, awaddr, awsize, a, exp_sz); end
        end
        if (c <= 1 + ww) begin
          checks++; if (axi_wdata !== d || axi_wstrb !== st) begin errors++; $display("FAIL wr_w_payload c%0d: got %h/%b want %h/%b", c, axi_wdata, axi_wstrb, d, st); end
        end
      end
      tick();
      req = 1'b0; rvalid = 1'b1; axi_rdata = $urandom; bvalid = 1'b1; awready = 1'b0; wready = 1'b0;
      #1;
      checks++; if (addr_ok !== 1'b1 || data_ok !== 1'b0) begin errors++; $display("FAIL wr_return_idle: got addr_ok=%b data_ok=%b want 1/0", addr_ok, data_ok); end
      checks++; if (rdata !== last_rdata) begin errors++; $display("FAIL wr_rdata_after: got %h want %h", rdata, last_rdata); end
      $display("write addr=%h size=%0d strb=%b data=%h awwait=%0d wwait=%0d bwait=%0d done@%0d", a, sz, st, d, aww, ww, bw, done_c);
    end
  endtask

  task automatic test_reset_mid();
    req = 1'b1; wr = 1'b0; addr = 32'h1c00_0100; size = 2'd2;
    arready = 1'b0; rvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    req = 1'b0; arready = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_arvalid: got %b want 1", arvalid); end
    tick();
    arready = 1'b0; rvalid = 1'b0;
    #1;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_mid_rready_before: got %b want 1", rready); end
    resetn = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_mid_rready: got %b want 0", rready); end
    checks++; if (arvalid !== 1'b0 || data_ok !== 1'b0) begin errors++; $display("FAIL rst_mid_outs: got ar=%b dok=%b want 00", arvalid, data_ok); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
    tick();
    resetn = 1'b1;
    last_rdata = 32'h0;
    tick();
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_addr_ok: got %b want 1", addr_ok); end
    $display("reset_mid: reset applied during read data phase");
  endtask

  initial begin
    test_reset();
    test_stray_idle(4);
    test_read(8);
    test_write(8);
    test_read(3);
    test_reset_mid();
    test_read(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
